// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } e_btn_state;

  // Defaults for a 50 MHz system clock: 20 ms debounce, 1 s long press.
  localparam int DB_CYCLES_50M   = 1_000_000;
  localparam int LONG_CYCLES_50M = 50_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, hold timer and
// registered level / press / release / long-press outputs.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50M,
  parameter int LONG_CYCLES = LONG_CYCLES_50M
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic           sync1_q, sync2_q;
  e_btn_state     state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           long_done_q, long_done_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;

  // Synchroniser resets to "released" so reset exit never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DBW'(1);
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      PRESSED: begin
        // The hold timer stays frozen on the edge that leaves for RELEASE_WAIT.
        if (sync2_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = DBW'(1);
        end else begin
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
          if (!long_done_q && (hold_cnt_d == HOLD_LAST)) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent synchronise/debounce channels
// producing clean levels and single-cycle press, release and long-press pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN       = 2,
  parameter int DB_CYCLES   = DB_CYCLES_50M,
  parameter int LONG_CYCLES = LONG_CYCLES_50M
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_debounce_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n[gi]),
        .btn_level   (btn_level[gi]),
        .btn_press   (btn_press[gi]),
        .btn_release (btn_release[gi]),
        .btn_long    (btn_long[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=8, LONG_CYCLES=32, N_BTN=2.
module tb_btn_conditioner;

  localparam int N_BTN = 2;
  localparam int DB    = 8;
  localparam int LONG  = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_long;
  logic [7:0]       obs;

  int vectors     = 0;
  int miscompares = 0;

  btn_conditioner #(
    .N_BTN       (N_BTN),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  // Bit order: level[1], level[0], press[1], press[0], release[1], release[0], long[1], long[0]
  assign obs = {btn_level, btn_press, btn_release, btn_long};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_n = 2'b11;
    repeat (3) step();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, 8'h00);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_exit k=%0d obs=%b exp=%b", k, obs, 8'h00);
      end
    end
  endtask

  // k counts edges from the first edge that samples the new raw value (k=1).
  task automatic test_clean_press();
    logic [7:0] exp;
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k >= 10), 1'b0, (k == 10), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clean_press k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k < 10), 2'b00, 1'b0, (k == 10), 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clean_release k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      btn_n[0] = (((c / 3) % 2) != 0);
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL bounce c=%0d obs=%b exp=%b", c, obs, 8'h00);
      end
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL bounce_settle k=%0d obs=%b exp=%b", k, obs, 8'h00);
      end
    end
  endtask

  task automatic test_long_press();
    logic [7:0] exp;
    btn_n[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {(k >= 10), 1'b0, (k == 10), 1'b0, 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_press_entry k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    // j counts edges after the one that raised btn_press[1].
    for (int j = 1; j <= 60; j++) begin
      step();
      exp = {1'b1, 1'b0, 2'b00, 2'b00, (j == LONG - 1), 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_press_hold j=%0d obs=%b exp=%b", j, obs, exp);
      end
    end
    btn_n[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {(k < 10), 1'b0, 2'b00, (k == 10), 1'b0, 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_press_release k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic [7:0] exp;
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {1'b0, (k >= 10), 1'b0, (k == 10), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL short_press_entry k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    for (int j = 1; j <= 15; j++) begin
      step();
      vectors++;
      if (obs !== 8'b0100_0000) begin
        miscompares++;
        $display("FAIL short_press_hold j=%0d obs=%b exp=%b", j, obs, 8'b0100_0000);
      end
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k < 10), 2'b00, 1'b0, (k == 10), 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL short_press_release k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    logic       lv, pr, rl;
    btn_n = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      step();
      lv  = (k >= 10);
      pr  = (k == 10);
      exp = {lv, lv, pr, pr, 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL simul_press k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    btn_n = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      step();
      lv  = (k < 10);
      rl  = (k == 10);
      exp = {lv, lv, 2'b00, rl, rl, 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL simul_release k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    btn_n[0] = 1'b0;
    // Edge 3 enters PRESS_WAIT; three more edges put it 4 counts in.
    for (int k = 1; k <= 6; k++) begin
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_mid_pre k=%0d obs=%b exp=%b", k, obs, 8'h00);
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_assert obs=%b exp=%b", obs, 8'h00);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_mid_during k=%0d obs=%b exp=%b", k, obs, 8'h00);
      end
    end
    reset = 1'b0;
    // Held button is re-detected from the first edge after reset deasserts.
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k >= 10), 1'b0, (k == 10), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_repress k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {1'b0, (k < 10), 2'b00, 1'b0, (k == 10), 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_release k=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioner for the raw push-buttons that drive the LED running-light controller.
- Synchronises each active-low board button to clk and debounces it.
- Produces a clean level plus single-cycle press, release and long-press pulses.
- The downstream controller consumes these pulses for direction reversal and speed stepping instead of sampling raw pins or clocking logic off button edges.

Parameters:
- N_BTN, 2, number of independent button channels.
- DB_CYCLES, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); legal range >= 2.
- LONG_CYCLES, 50_000_000, stable-press duration in clk cycles that qualifies as a long press (1 s at 50 MHz); legal range > DB_CYCLES.

Ports:
- clk  in  1  system clock; sole clock of the block.
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_level  out  N_BTN  debounced state, active-high (1 = pressed).
- btn_press  out  N_BTN  one-cycle pulse when btn_level rises.
- btn_release  out  N_BTN  one-cycle pulse when btn_level falls.
- btn_long  out  N_BTN  one-cycle pulse, at most once per press, after LONG_CYCLES of continuous press.

Behaviour:
- All outputs are registered. Channels are fully independent; simultaneous events on different channels all fire in the same cycle.
- Synchroniser: 2-FF per channel on btn_n; both FFs reset to 1 (released). Downstream logic uses the second FF only (sync).
- Counters: db_cnt is $clog2(DB_CYCLES) bits; hold_cnt is $clog2(LONG_CYCLES) bits; long_done is a 1-bit flag. Per-channel FSM states are IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE: on sync==0 -> PRESS_WAIT with db_cnt=1.
- PRESS_WAIT:
  - sync==1 (bounce) -> IDLE, db_cnt=0.
  - Else if db_cnt==DB_CYCLES-1 -> PRESSED; btn_level<=1; btn_press<=1; hold_cnt=0; long_done=0.
  - Else db_cnt++.
- PRESSED:
  - hold_cnt increments, saturating at LONG_CYCLES-1.
  - When hold_cnt reaches LONG_CYCLES-1 with long_done==0: btn_long<=1 for one cycle, then long_done=1.
  - sync==1 -> RELEASE_WAIT with db_cnt=1; hold_cnt frozen.
- RELEASE_WAIT:
  - sync==0 (bounce) -> PRESSED, hold_cnt resumes, long_done kept.
  - Else if db_cnt==DB_CYCLES-1 -> IDLE; btn_level<=0; btn_release<=1.
  - Else db_cnt++.
- Latency:
  - Raw input stable from sampling edge t0 -> btn_level/btn_press/btn_release visible after edge t0+DB_CYCLES+1.
  - btn_long is visible LONG_CYCLES-1 edges after btn_press rises.
- Pulses are exactly one cycle wide. btn_long never fires after btn_release for the same press. A bounce during PRESS_WAIT or RELEASE_WAIT never produces a pulse.
- Reset (asserted at any time, including mid-debounce or mid-hold):
  - All FSMs go to IDLE; counters and long_done clear; all outputs 0; sync FFs go to 1.
  - No pulse is generated on reset entry or exit.
  - A button held through reset release is detected as a fresh press after DB_CYCLES+1 cycles.
- No metastability-dependent behaviour beyond the 2-FF synchroniser. No arithmetic overflow is possible (counters bounded/saturating).

Decomposition:
- Shared package btn_pkg: typedef enum e_btn_state {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}; default cycle constants for 50 MHz (DB_CYCLES_50M, LONG_CYCLES_50M).
- Sub-module btn_debounce_ch: one channel (synchroniser, FSM, both counters, pulse registers). The top instantiates N_BTN copies via generate.

Test Plan (DB_CYCLES=8, LONG_CYCLES=32, N_BTN=2):
- Clean press: btn_n[0] 1->0 sampled at edge 10, held -> btn_level[0]=1 and btn_press[0]=1 after edge 19 only; btn_press low at edge 20; channel 1 outputs stay 0.
- Bounce reject: btn_n[0] toggles 0/1 every 3 cycles for 40 cycles, then stays 1 -> btn_level[0], btn_press[0], btn_release[0] remain 0 throughout.
- Long press: hold btn_n[1]=0 for 60 cycles after btn_press[1] -> exactly one btn_long[1] pulse 31 edges after btn_press[1]. Then release -> btn_release[1] 9 edges after the first sampled 1; btn_long never repeats.
- Short press: hold pressed 15 cycles past btn_press, then release -> btn_release fires; btn_long never fires.
- Simultaneous: both btn_n go 0 at the same edge -> btn_press[0] and btn_press[1] pulse in the same cycle.
- Reset mid-operation: assert reset 4 cycles into PRESS_WAIT with the button held, release reset -> all outputs 0 during reset, no pulse on exit; btn_press fires 9 edges after reset deassert.
